muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int c_n    = WIDTH / UNROLL;
    localparam int c_cntw = $clog2(c_n + 1);
    localparam logic [c_cntw-1:0] c_cnt_init = c_cntw'(c_n);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]         r_state;
    logic [c_cntw-1:0]  r_cnt;
    logic               r_fix_ph;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dzero;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_fixed;
    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_sum;
    logic               w_ge;

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Signed functs have funct[0] == 0; magnitudes are taken at acceptance.
    assign w_sa = ~funct[0] & a[WIDTH-1];
    assign w_sb = ~funct[0] & b[WIDTH-1];
    assign w_ma = w_sa ? -a : a;
    assign w_mb = w_sb ? -b : b;

    // Divide: acc = {remainder, dividend->quotient}; multiply: acc = {product hi, multiplier->product lo}.
    always_comb begin
        w_acc = r_acc;
        w_t   = '0;
        w_sum = '0;
        w_ge  = 1'b0;
        for (int i = 0; i < UNROLL; i++) begin
            if (r_is_div) begin
                w_t  = {w_acc[2*WIDTH-1:WIDTH], w_acc[WIDTH-1]};
                w_ge = (w_t >= {1'b0, r_opb});
                if (w_ge) begin
                    w_t = w_t - {1'b0, r_opb};
                end
                w_acc = {w_t[WIDTH-1:0], w_acc[WIDTH-2:0], w_ge};
            end else begin
                w_sum = {1'b0, w_acc[2*WIDTH-1:WIDTH]} + (w_acc[0] ? {1'b0, r_opb} : '0);
                w_acc = {w_sum, w_acc[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        w_fixed = r_acc;
        if (r_is_div) begin
            w_fixed[WIDTH-1:0]       = r_dzero ? '1 :
                                       (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
            w_fixed[2*WIDTH-1:WIDTH] = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end else if (r_neg_q) begin
            w_fixed = -r_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_fix_ph <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dzero  <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_calc: begin
                    if (flush) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc;
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state  <= c_fix;
                            r_fix_ph <= 1'b0;
                        end
                    end
                end
                c_fix: begin
                    // First FIX cycle corrects signs in place, second commits to HI/LO.
                    if (flush) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end else if (!r_fix_ph) begin
                        r_acc    <= w_fixed;
                        r_fix_ph <= 1'b1;
                    end else begin
                        r_hi    <= r_acc[2*WIDTH-1:WIDTH];
                        r_lo    <= r_acc[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_done;
                    end
                end
                default: begin
                    if (start && !flush) begin
                        r_state  <= c_calc;
                        r_cnt    <= c_cnt_init;
                        r_busy   <= 1'b1;
                        r_is_div <= funct[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_dzero  <= (b == '0);
                        r_acc    <= {{WIDTH{1'b0}}, (funct[1] ? w_ma : w_mb)};
                        r_opb    <= funct[1] ? w_mb : w_ma;
                    end else begin
                        r_state <= c_idle;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed bench for muldiv_unit with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int LAT1 = 34;
    localparam int LAT4 = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1 = 1'b0;
    logic        flush1 = 1'b0;
    logic [1:0]  funct1 = 2'b00;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        busy1, done1;
    logic [31:0] hi1, lo1;

    logic        start4 = 1'b0;
    logic        flush4 = 1'b0;
    logic [1:0]  funct4 = 2'b00;
    logic [31:0] a4 = '0;
    logic [31:0] b4 = '0;
    logic        busy4, done4;
    logic [31:0] hi4, lo4;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .funct(funct1), .a(a1), .b(b1),
        .flush(flush1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    muldiv_unit #(.WIDTH(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .funct(funct4), .a(a4), .b(b4),
        .flush(flush4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model_res(input logic [1:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        logic signed [63:0] px, py;
        logic signed [31:0] sx, sy;
        logic [31:0] q, r;
        case (f)
            2'b00: begin
                px = {{32{x[31]}}, x};
                py = {{32{y[31]}}, y};
                return px * py;
            end
            2'b01: return {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sx = x;
                sy = y;
                q  = sx / sy;
                r  = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Reference for the UNROLL=1 instance: an operation is in flight for LAT1 cycles.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    logic        m_busy;
    assign m_busy = (m_left != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left != 0) begin
            m_done <= 1'b0;
            if (flush1) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end
        end else begin
            m_done <= 1'b0;
            if (start1 && !flush1) begin
                m_left <= LAT1;
                m_res  <= model_res(funct1, a1, b1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("cycle {busy,done,hi,lo}", {busy1, done1, hi1, lo1},
                          {m_busy, m_done, m_hi, m_lo});
    end

    task automatic run_op(input string nm, input logic [1:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input bit poke);
        int k;
        @(posedge clk); #2;
        start1 = 1'b1; funct1 = f; a1 = x; b1 = y;
        @(posedge clk); #2;
        start1 = 1'b0; a1 = '0; b1 = '0;
        k = 0;
        while (k < 60) begin
            @(posedge clk);
            k++;
            #1;
            if (done1) break;
            if (poke && k == 5) begin
                start1 = 1'b1; funct1 = 2'b11; a1 = 32'd1; b1 = 32'd1;
            end else begin
                start1 = 1'b0;
            end
        end
        start1 = 1'b0;
        check({nm, " latency"}, 66'(k), 66'(LAT1));
        check({nm, " hi"}, 66'(hi1), 66'(eh));
        check({nm, " lo"}, 66'(lo1), 66'(el));
    endtask

    task automatic wait_done4(output int k);
        k = 0;
        while (k < 30) begin
            @(posedge clk);
            k++;
            #1;
            if (done4) break;
        end
    endtask

    initial begin
        int  k;
        bit  saw_done;
        chk_en = 1'b1;
        #12;
        check("reset state", {busy1, done1, hi1, lo1}, 66'h0);
        @(posedge clk); #3; rst_n = 1'b1;

        run_op("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("MULT -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
        run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("DIVU 7/0", 2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
        run_op("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("DIV -8/0", 2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0);

        // start together with flush while idle is dropped
        @(posedge clk); #2;
        start1 = 1'b1; flush1 = 1'b1; funct1 = 2'b01; a1 = 32'd2; b1 = 32'd3;
        @(posedge clk); #2;
        start1 = 1'b0; flush1 = 1'b0;
        check("start+flush busy", 66'(busy1), 66'h0);

        // flush a DIVU partway through
        @(posedge clk); #2;
        start1 = 1'b1; funct1 = 2'b11; a1 = 32'd100; b1 = 32'd3;
        @(posedge clk); #2;
        start1 = 1'b0;
        repeat (9) @(posedge clk);
        #2; flush1 = 1'b1;
        @(posedge clk); #2;
        flush1 = 1'b0;
        check("flush busy", 66'(busy1), 66'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw_done |= done1;
        end
        check("flush no done", 66'(saw_done), 66'h0);
        check("flush hi/lo kept", 66'({hi1, lo1}), 66'({32'hFFFF_FFF8, 32'hFFFF_FFFF}));

        // asynchronous reset in the middle of a MULT
        @(posedge clk); #2;
        start1 = 1'b1; funct1 = 2'b00; a1 = 32'd9; b1 = 32'd9;
        @(posedge clk); #2;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        check("async reset", {busy1, done1, hi1, lo1}, 66'h0);
        @(posedge clk); #3; rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw_done |= done1;
        end
        check("reset no done", 66'(saw_done), 66'h0);
        run_op("MULTU 2*3", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

        // UNROLL=4 instance, including a start accepted in the DONE cycle
        @(posedge clk); #2;
        start4 = 1'b1; funct4 = 2'b01; a4 = 32'h1234_5678; b4 = 32'h9ABC_DEF0;
        @(posedge clk); #2;
        start4 = 1'b0;
        wait_done4(k);
        check("U4 MULTU latency", 66'(k), 66'(LAT4));
        check("U4 MULTU hi", 66'(hi4), 66'h0B00_EA4E);
        check("U4 MULTU lo", 66'(lo4), 66'h242D_2080);
        start4 = 1'b1; funct4 = 2'b00; a4 = 32'hFFFF_FFFD; b4 = 32'd5;
        @(posedge clk); #2;
        start4 = 1'b0;
        check("U4 b2b accepted", 66'({busy4, done4}), 66'b10);
        wait_done4(k);
        check("U4 MULT latency", 66'(k), 66'(LAT4));
        check("U4 MULT hi/lo", 66'({hi4, lo4}), 66'({32'hFFFF_FFFF, 32'hFFFF_FFF1}));
        @(posedge clk); #1;
        check("U4 done pulse", 66'({busy4, done4}), 66'h0);

        @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
